casper100g_tx_arbiter: RTL and testbench

Packet-level round-robin arbiter that shares one 100G TX streaming interface (512-bit data, dest IP/port, end-of-frame) among N yellow-block requesters. It sits in the user_clk domain, between the user TX streams and the 100G Ethernet block's streaming TX input. A grant is held for a whole frame. Oversize frames are truncated and their remainder is dropped, so one requester cannot lock the link.

---
 rtl/casper100g_tx_arb_pkg.sv | 35 +++
 rtl/casper100g_rr_pick.sv | 29 ++
 rtl/casper100g_tx_arbiter.sv | 139 +++++++++++++
 tb/tb_casper100g_tx_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/casper100g_tx_arb_pkg.sv
// Shared types, widths and the round-robin search used by the 100G TX arbiter.
// Purely declarative: no state, no latency, no flow control.
// rr_next is written for up to MAX_PORTS requesters and is trimmed by n_ports.
package casper100g_tx_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2
    } arb_state_t;

    localparam int IP_W      = 32;
    localparam int PORT_W    = 16;
    localparam int MAX_PORTS = 8;

    // First requester found scanning upward from ptr+1, wrapping at n_ports.
    function automatic logic [2:0] rr_next(input logic [MAX_PORTS-1:0] req,
                                           input logic [2:0]           ptr,
                                           input int                   n_ports);
        logic [2:0] win;
        logic       found;
        int         idx;
        win   = '0;
        found = 1'b0;
        for (int k = 1; k <= MAX_PORTS; k++) begin
            idx = (int'(ptr) + k) % n_ports;
            if (k <= n_ports && !found && req[idx[2:0]]) begin
                win   = idx[2:0];
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/casper100g_rr_pick.sv
// Round-robin priority search: picks the first set request after ptr.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is consumed.
module casper100g_rr_pick
    import casper100g_tx_arb_pkg::*;
#(
    parameter  int N_PORTS = 4,
    localparam int GW      = $clog2(N_PORTS)
) (
    input  logic [N_PORTS-1:0] req,
    input  logic [GW-1:0]      ptr,
    output logic [GW-1:0]      win,
    output logic               found
);

    logic [MAX_PORTS-1:0] req_ext;
    logic [2:0]           ptr_ext;
    logic [2:0]           win_ext;

    always_comb begin
        req_ext                = '0;
        req_ext[N_PORTS-1:0]   = req;
        ptr_ext                = 3'(ptr);
        win_ext                = rr_next(req_ext, ptr_ext, N_PORTS);
        win                    = GW'(win_ext);
        found                  = |req;
    end

endmodule

// File: rtl/casper100g_tx_arbiter.sv
// Frame-level round-robin arbiter sharing one 100G TX stream; truncates frames at MAX_BEATS.
// Latency: one-cycle arbitration bubble per frame, then data passes combinationally.
// Backpressure: tx_ready is forwarded to the granted port only; TX_ARB_PKT_COUNT_EN adds frame counters.
module casper100g_tx_arbiter
    import casper100g_tx_arb_pkg::*;
#(
    parameter  int N_PORTS   = 4,
    parameter  int DATA_W    = 512,
    parameter  int MAX_BEATS = 144,
    localparam int GW        = $clog2(N_PORTS)
) (
    input  logic                      user_clk,
    input  logic                      gbe_rst,
    input  logic [N_PORTS-1:0]        port_enable,
    input  logic [N_PORTS*DATA_W-1:0] req_data,
    input  logic [N_PORTS-1:0]        req_valid,
    input  logic [N_PORTS-1:0]        req_eof,
    input  logic [N_PORTS*IP_W-1:0]   req_dest_ip,
    input  logic [N_PORTS*PORT_W-1:0] req_dest_port,
    output logic [N_PORTS-1:0]        req_ready,
    output logic [DATA_W-1:0]         tx_data,
    output logic                      tx_valid,
    output logic                      tx_eof,
    output logic [IP_W-1:0]           tx_dest_ip,
    output logic [PORT_W-1:0]         tx_dest_port,
    input  logic                      tx_ready,
    output logic [GW-1:0]             grant_idx,
    output logic                      busy,
    output logic                      oversize_err,
    output logic [N_PORTS*32-1:0]     pkt_count
);

    localparam int              CNT_W    = $clog2(MAX_BEATS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BEATS - 1);
    localparam logic [CNT_W-1:0] SAT_CNT  = CNT_W'(MAX_BEATS);

    arb_state_t       state, state_nxt;
    logic [GW-1:0]    g, rr_ptr, win;
    logic             found;
    logic [CNT_W-1:0] beat_cnt;
    logic             sel_valid, sel_eof, at_limit;
    logic             xfer_pass, xfer_drop, pass_eof, drop_eof, trunc;

    casper100g_rr_pick #(.N_PORTS(N_PORTS)) u_pick (
        .req   (port_enable & req_valid),
        .ptr   (rr_ptr),
        .win   (win),
        .found (found)
    );

    always_comb begin
        sel_valid = req_valid[g];
        sel_eof   = req_eof[g];
        at_limit  = (beat_cnt == LAST_CNT);
        xfer_pass = (state == PASS) && sel_valid && tx_ready;
        xfer_drop = (state == DROP) && sel_valid;
        pass_eof  = xfer_pass && sel_eof;
        drop_eof  = xfer_drop && sel_eof;
        trunc     = xfer_pass && !sel_eof && at_limit;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = PASS;
            PASS:    if (pass_eof) state_nxt = IDLE;
                     else if (trunc) state_nxt = DROP;
            DROP:    if (drop_eof) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge user_clk) begin
        if (gbe_rst) state <= IDLE;
        else         state <= state_nxt;
    end

    // Only the granted port sees a ready; DROP drains it regardless of tx_ready.
    always_comb begin
        req_ready = '0;
        tx_data   = '0;
        tx_valid  = 1'b0;
        tx_eof    = 1'b0;
        if (state == PASS) begin
            req_ready[g] = tx_ready;
            tx_data      = req_data[int'(g)*DATA_W +: DATA_W];
            tx_valid     = sel_valid;
            tx_eof       = sel_valid && (sel_eof || at_limit);
        end else if (state == DROP) begin
            req_ready[g] = 1'b1;
        end
    end

    always_ff @(posedge user_clk) begin
        if (gbe_rst) begin
            rr_ptr       <= GW'(N_PORTS - 1);
            g            <= '0;
            beat_cnt     <= '0;
            tx_dest_ip   <= '0;
            tx_dest_port <= '0;
            oversize_err <= 1'b0;
        end else begin
            oversize_err <= trunc;
            if (state == IDLE && found) begin
                g            <= win;
                tx_dest_ip   <= req_dest_ip[int'(win)*IP_W +: IP_W];
                tx_dest_port <= req_dest_port[int'(win)*PORT_W +: PORT_W];
                beat_cnt     <= '0;
            end
            if ((xfer_pass || xfer_drop) && beat_cnt != SAT_CNT)
                beat_cnt <= beat_cnt + CNT_W'(1);
            if (pass_eof || drop_eof)
                rr_ptr <= g;
        end
    end

    assign grant_idx = g;
    assign busy      = (state != IDLE);

`ifdef TX_ARB_PKT_COUNT_EN
    // A truncated frame is counted at its forced eof, never again at the source eof.
    logic [31:0] pkt_cnt_q [N_PORTS];

    always_ff @(posedge user_clk) begin
        if (gbe_rst) begin
            for (int i = 0; i < N_PORTS; i++) pkt_cnt_q[i] <= '0;
        end else if (pass_eof || trunc) begin
            pkt_cnt_q[g] <= pkt_cnt_q[g] + 32'd1;
        end
    end

    for (genvar i = 0; i < N_PORTS; i++) begin : g_cnt
        assign pkt_count[i*32 +: 32] = pkt_cnt_q[i];
    end
`else
    assign pkt_count = '0;
`endif

endmodule

// File: tb/tb_casper100g_tx_arbiter.sv
// Scoreboard bench for casper100g_tx_arbiter: per-port source queues, expected TX beats queued at send time.
module tb_casper100g_tx_arbiter;

    localparam int NP   = 4;
    localparam int DW   = 64;
    localparam int MAXB = 4;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          eof;
        logic [31:0]   ip;
        logic [15:0]   dport;
        logic [1:0]    gnt;
    } beat_t;

    logic              user_clk = 1'b0;
    logic              gbe_rst;
    logic [NP-1:0]     port_enable, req_valid, req_eof, req_ready;
    logic [NP*DW-1:0]  req_data;
    logic [NP*32-1:0]  req_dest_ip;
    logic [NP*16-1:0]  req_dest_port;
    logic [DW-1:0]     tx_data;
    logic              tx_valid, tx_eof, tx_ready;
    logic [31:0]       tx_dest_ip;
    logic [15:0]       tx_dest_port;
    logic [1:0]        grant_idx;
    logic              busy, oversize_err;
    logic [NP*32-1:0]  pkt_count;

    beat_t         srcq [NP][$];
    beat_t         exp_q[$];
    logic [NP-1:0] fire = '0;
    int            n_chk = 0, n_fail = 0, ovs_cnt = 0, frame_id = 0;
    int            exp_pkt [NP];

    always #5 user_clk = ~user_clk;

    casper100g_tx_arbiter #(.N_PORTS(NP), .DATA_W(DW), .MAX_BEATS(MAXB)) dut (
        .user_clk(user_clk), .gbe_rst(gbe_rst), .port_enable(port_enable),
        .req_data(req_data), .req_valid(req_valid), .req_eof(req_eof),
        .req_dest_ip(req_dest_ip), .req_dest_port(req_dest_port), .req_ready(req_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_eof(tx_eof),
        .tx_dest_ip(tx_dest_ip), .tx_dest_port(tx_dest_port), .tx_ready(tx_ready),
        .grant_idx(grant_idx), .busy(busy), .oversize_err(oversize_err), .pkt_count(pkt_count)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge user_clk);
        #2;
    endtask

    task automatic send_frame(input int p, input int nb, input logic [31:0] ip,
                              input logic [15:0] dp, input int exp_lim);
        beat_t b;
        for (int k = 0; k < nb; k++) begin
            b.data  = {$urandom(), 8'(p), 16'(frame_id), 8'(k)};
            b.eof   = (k == nb - 1);
            b.ip    = ip;
            b.dport = dp;
            b.gnt   = 2'(p);
            srcq[p].push_back(b);
            if (k < exp_lim && k < MAXB) begin
                if (k == MAXB - 1) b.eof = 1'b1;
                exp_q.push_back(b);
            end
        end
        frame_id++;
    endtask

    task automatic wait_idle(input string tag);
        int t = 0;
        do begin
            step();
            t++;
        end while ((exp_q.size() != 0 || busy) && t < 300);
        check_val(tag, 64'((exp_q.size() == 0) && !busy), 64'd1);
    endtask

    // Source drivers and TX monitor, all stepped from the falling edge.
    initial begin
        beat_t e;
        forever begin
            @(negedge user_clk);
            for (int i = 0; i < NP; i++) begin
                if (fire[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
                if (srcq[i].size() > 0) begin
                    req_valid[i]               = 1'b1;
                    req_eof[i]                 = srcq[i][0].eof;
                    req_data[i*DW +: DW]       = srcq[i][0].data;
                    req_dest_ip[i*32 +: 32]    = srcq[i][0].ip;
                    req_dest_port[i*16 +: 16]  = srcq[i][0].dport;
                end else begin
                    req_valid[i] = 1'b0;
                    req_eof[i]   = 1'b0;
                end
            end
            #1;
            fire = req_valid & req_ready;
            if (oversize_err) ovs_cnt++;
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    check_val("unexpected_beat", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_val("tx_data", tx_data, e.data);
                    check_val("tx_eof", 64'(tx_eof), 64'(e.eof));
                    check_val("tx_dest_ip", 64'(tx_dest_ip), 64'(e.ip));
                    check_val("tx_dest_port", 64'(tx_dest_port), 64'(e.dport));
                    check_val("grant_idx", 64'(grant_idx), 64'(e.gnt));
                    if (e.eof) exp_pkt[e.gnt]++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1);
    end

    initial begin
        logic [3:0]  pat;
        logic [31:0] exp_cnt;
        pat           = 4'b1001;
        gbe_rst       = 1'b1;
        port_enable   = '1;
        req_valid     = '0;
        req_eof       = '0;
        req_data      = '0;
        req_dest_ip   = '0;
        req_dest_port = '0;
        tx_ready      = 1'b1;
        for (int i = 0; i < NP; i++) exp_pkt[i] = 0;
        repeat (3) step();
        check_val("rst_tx_valid", 64'(tx_valid), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_req_ready", 64'(req_ready), 64'd0);
        check_val("rst_grant_idx", 64'(grant_idx), 64'd0);
        gbe_rst = 1'b0;
        step();
        check_val("post_rst_dest_ip", 64'(tx_dest_ip), 64'd0);
        check_val("post_rst_ovs", 64'(oversize_err), 64'd0);
        check_val("post_rst_tx_eof", 64'(tx_eof), 64'd0);

        // Single frame from port 1: one bubble cycle, then three beats.
        send_frame(1, 3, 32'hc0a805c9, 16'h2710, MAXB);
        step();
        check_val("bubble_tx_valid", 64'(tx_valid), 64'd0);
        check_val("bubble_req_ready", 64'(req_ready), 64'd0);
        check_val("bubble_busy", 64'(busy), 64'd0);
        step();
        check_val("grant_busy", 64'(busy), 64'd1);
        check_val("grant_idx_p1", 64'(grant_idx), 64'd1);
        check_val("grant_req_ready", 64'(req_ready), 64'b0010);
        check_val("grant_dest_ip", 64'(tx_dest_ip), 64'hc0a805c9);
        wait_idle("frame_p1_drain");

        // Reset on the second of five beats; the rest of the frame is abandoned.
        send_frame(0, 5, 32'h0a000001, 16'h1111, 2);
        repeat (3) step();
        gbe_rst = 1'b1;
        srcq[0].delete();
        for (int i = 0; i < NP; i++) exp_pkt[i] = 0;
        step();
        check_val("midrst_tx_valid", 64'(tx_valid), 64'd0);
        check_val("midrst_busy", 64'(busy), 64'd0);
        check_val("midrst_grant_idx", 64'(grant_idx), 64'd0);
        check_val("midrst_dest_ip", 64'(tx_dest_ip), 64'd0);
        check_val("midrst_dest_port", 64'(tx_dest_port), 64'd0);
        check_val("midrst_req_ready", 64'(req_ready), 64'd0);
        check_val("midrst_exp_empty", 64'(exp_q.size()), 64'd0);
        gbe_rst = 1'b0;
        // Ports 0 and 3 request together: port 0 has priority after reset.
        send_frame(0, 2, 32'h0a000002, 16'h2222, MAXB);
        send_frame(3, 2, 32'h0a000003, 16'h3333, MAXB);
        wait_idle("prio_drain");

        // Ports 0 and 2 alternate; disabled port 1 is never granted.
        port_enable = 4'b1101;
        send_frame(1, 2, 32'h0a000011, 16'h0001, 0);
        send_frame(0, 2, 32'h0a000010, 16'h0a0a, MAXB);
        send_frame(2, 2, 32'h0a000012, 16'h0c0c, MAXB);
        send_frame(0, 2, 32'h0a000010, 16'h0a0b, MAXB);
        send_frame(2, 2, 32'h0a000012, 16'h0c0d, MAXB);
        wait_idle("alt_drain");
        check_val("disabled_port_untouched", 64'(srcq[1].size()), 64'd2);
        srcq[1].delete();
        step();
        step();
        port_enable = '1;

        // tx_ready toggled 1,0,0,1 during a four-beat frame.
        send_frame(3, 4, 32'h0a000033, 16'h4444, MAXB);
        for (int c = 0; c < 60; c++) begin
            @(negedge user_clk);
            tx_ready = pat[c % 4];
            #2;
            if (busy) check_val("ready_mirror", 64'(req_ready), 64'({tx_ready, 3'b000}));
            if (exp_q.size() == 0 && !busy) break;
        end
        tx_ready = 1'b1;
        check_val("toggle_drain", 64'(exp_q.size()), 64'd0);

        // Six-beat frame is cut at four beats; two source beats are drained.
        ovs_cnt = 0;
        send_frame(3, 6, 32'h0a000044, 16'h5555, MAXB);
        wait_idle("trunc_drain");
        check_val("ovs_pulses", 64'(ovs_cnt), 64'd1);
        check_val("trunc_src_consumed", 64'(srcq[3].size()), 64'd0);

        step();
        for (int i = 0; i < NP; i++) begin
`ifdef TX_ARB_PKT_COUNT_EN
            exp_cnt = 32'(exp_pkt[i]);
`else
            exp_cnt = 32'd0;
`endif
            check_val($sformatf("pkt_count_%0d", i), 64'(pkt_count[i*32 +: 32]), 64'(exp_cnt));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
